// File: rtl/period_discriminator.sv
// Carrier-loop period discriminator: measures input and NCO periods over 2^AVG_LOG2 cycles and emits delta = T_in - T_gen.
// Define PERIOD_DISC_SATURATE_EN to clamp delta to +/-DELTA_LIM (lock still judged on the unclamped value).
module period_discriminator #(
  parameter int                 W_N_MAX   = 7,
  parameter int                 AVG_LOG2  = 2,
  parameter logic signed [31:0] HYST      = 32'sd1_000_000,
  parameter int                 DELTA_LIM = 1024,
  parameter int                 LOCK_TOL  = 2
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic               clk_en,
  input  logic signed [31:0] signal_input,
  input  logic signed [31:0] signal_gen,
  output logic signed [31:0] delta,
  output logic               delta_valid,
  output logic               lock,
  output logic               timeout
);
  localparam int W_CNT  = W_N_MAX + AVG_LOG2 + 1;
  localparam int W_EDGE = AVG_LOG2 + 1;
  localparam logic [W_CNT-1:0]   CNT_MAX   = '1;
  localparam logic [W_EDGE-1:0]  EDGE_LAST = W_EDGE'(1 << AVG_LOG2);
  localparam logic [W_CNT:0]     TOL       = (W_CNT+1)'(LOCK_TOL);
  localparam logic signed [31:0] HYST_NEG  = -HYST;
  localparam logic signed [31:0] LIM_POS   = 32'(DELTA_LIM);
  localparam logic signed [31:0] LIM_NEG   = -LIM_POS;
`ifdef PERIOD_DISC_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_ARM, ST_MEAS, ST_EMIT} state_t;
  state_t state_q, state_d;

  // Channel index 0 is the sampled input, index 1 is the NCO.
  logic [1:0][31:0]       samples;
  logic [1:0]             lvl_q, lvl_d, lvl_d1_q, rise;
  logic [1:0]             started_q, started_d, done_q, done_d;
  logic [1:0][W_CNT-1:0]  cnt_q, cnt_d, t_q, t_d;
  logic [1:0][W_EDGE-1:0] edge_q, edge_d;

  logic emit, tmo, tmo_hit;
  logic signed [W_CNT:0] raw;
  logic [W_CNT:0]        raw_abs;
  logic                  in_tol;
  logic signed [31:0]    raw_ext, sat, delta_d;
  logic signed [31:0]    delta_q;
  logic                  delta_valid_q, timeout_q, lock_q;
  logic [1:0]            lock_cnt_q;

  assign samples = {signal_gen, signal_input};
  assign rise    = lvl_q & ~lvl_d1_q;

  always_comb begin
    lvl_d     = lvl_q;
    started_d = started_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    t_d       = t_q;
    edge_d    = edge_q;
    for (int ch = 0; ch < 2; ch++) begin
      if ($signed(samples[ch]) >= HYST)          lvl_d[ch] = 1'b1;
      else if ($signed(samples[ch]) <= HYST_NEG) lvl_d[ch] = 1'b0;
      if (state_q == ST_ARM) begin
        started_d[ch] = 1'b0;
        done_d[ch]    = 1'b0;
        cnt_d[ch]     = '0;
        edge_d[ch]    = '0;
      end else if (state_q == ST_MEAS) begin
        if (!started_q[ch]) begin
          started_d[ch] = rise[ch];
        end else begin
          // Counter keeps running after done so a stalled partner channel still times out.
          if (cnt_q[ch] != CNT_MAX) cnt_d[ch] = cnt_q[ch] + 1'b1;
          if (rise[ch] && !done_q[ch]) begin
            edge_d[ch] = edge_q[ch] + 1'b1;
            if (edge_d[ch] == EDGE_LAST) begin
              done_d[ch] = 1'b1;
              t_d[ch]    = cnt_q[ch] + 1'b1;
            end
          end
        end
      end
    end
  end

  assign tmo_hit = (started_q[0] && cnt_d[0] == CNT_MAX) ||
                   (started_q[1] && cnt_d[1] == CNT_MAX);

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    tmo     = 1'b0;
    unique case (state_q)
      ST_ARM:  state_d = ST_MEAS;
      ST_MEAS: begin
        if (&done_q) begin
          state_d = ST_EMIT;
        end else if (tmo_hit && !(&done_d)) begin
          state_d = ST_ARM;
          tmo     = 1'b1;
        end
      end
      ST_EMIT: begin
        state_d = ST_ARM;
        emit    = 1'b1;
      end
      default: state_d = ST_ARM;
    endcase
  end

  assign raw     = $signed({1'b0, t_q[0]}) - $signed({1'b0, t_q[1]});
  assign raw_ext = {{(31-W_CNT){raw[W_CNT]}}, raw};
  assign raw_abs = raw[W_CNT] ? -raw : raw;
  assign in_tol  = (raw_abs <= TOL);
  assign sat     = (raw_ext > LIM_POS) ? LIM_POS : ((raw_ext < LIM_NEG) ? LIM_NEG : raw_ext);
  assign delta_d = SAT_EN ? sat : raw_ext;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= ST_ARM;
      lvl_q         <= '0;
      lvl_d1_q      <= '0;
      started_q     <= '0;
      done_q        <= '0;
      cnt_q         <= '0;
      t_q           <= '0;
      edge_q        <= '0;
      delta_q       <= '0;
      delta_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      lock_q        <= 1'b0;
      lock_cnt_q    <= '0;
    end else begin
      // Pulses clear on the next clock even while clk_en is low.
      delta_valid_q <= clk_en & emit;
      timeout_q     <= clk_en & tmo;
      if (clk_en) begin
        state_q   <= state_d;
        lvl_q     <= lvl_d;
        lvl_d1_q  <= lvl_q;
        started_q <= started_d;
        done_q    <= done_d;
        cnt_q     <= cnt_d;
        t_q       <= t_d;
        edge_q    <= edge_d;
        if (emit) begin
          delta_q <= delta_d;
          if (in_tol) begin
            if (lock_cnt_q == 2'd3) lock_q <= 1'b1;
            else                    lock_cnt_q <= lock_cnt_q + 2'd1;
          end else begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
          end
        end
        if (tmo) begin
          lock_cnt_q <= '0;
          lock_q     <= 1'b0;
        end
      end
    end
  end

  assign delta       = delta_q;
  assign delta_valid = delta_valid_q;
  assign lock        = lock_q;
  assign timeout     = timeout_q;
endmodule

// File: tb/tb_period_discriminator.sv
// Directed bench for period_discriminator: square-wave stimulus with hand-computed period errors.
module tb_period_discriminator;
  localparam logic signed [31:0] HI = 32'sd2_000_000_000;
  localparam logic signed [31:0] LO = -32'sd2_000_000_000;
  // 400 - 440 = -40, clamped to -32 when saturation is built in.
`ifdef PERIOD_DISC_SATURATE_EN
  localparam longint EXP_DIFF = -32;
`else
  localparam longint EXP_DIFF = -40;
`endif

  logic               clk;
  logic               reset_l;
  logic               clk_en;
  logic signed [31:0] signal_input;
  logic signed [31:0] signal_gen;
  logic signed [31:0] delta;
  logic               delta_valid;
  logic               lock;
  logic               timeout;

  period_discriminator #(.DELTA_LIM(32)) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .clk_en       (clk_en),
    .signal_input (signal_input),
    .signal_gen   (signal_gen),
    .delta        (delta),
    .delta_valid  (delta_valid),
    .lock         (lock),
    .timeout      (timeout)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int per_in, per_gen, en_div;
  int ph_in, ph_gen, div_cnt;
  bit noise_in;
  bit ok, seen_to, seen_dv;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Driver: one clock per call; samples outputs at the negedge, then presents the next inputs.
  task automatic tick();
    @(negedge clk);
    div_cnt = (div_cnt + 1) % en_div;
    clk_en  = (div_cnt == 0);
    if (clk_en) begin
      ph_in  = (ph_in + 1) % per_in;
      ph_gen = (ph_gen + 1) % per_gen;
    end
    if (noise_in) signal_input = int'($urandom_range(1_000_000, 0)) - 500_000;
    else          signal_input = (ph_in < per_in / 2) ? HI : LO;
    signal_gen = (ph_gen < per_gen / 2) ? HI : LO;
  endtask

  task automatic restart();
    ph_in        = per_in / 2 - 1;
    ph_gen       = per_gen / 2 - 1;
    div_cnt      = en_div - 1;
    signal_input = LO;
    signal_gen   = LO;
  endtask

  task automatic wait_valid(input int max_cycles, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (delta_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_l  = 1'b0;
    clk_en   = 1'b0;
    noise_in = 1'b0;
    per_in   = 100;
    per_gen  = 110;
    en_div   = 1;
    restart();
    repeat (3) tick();
    check("rst_delta",   delta, 0);
    check("rst_valid",   delta_valid, 0);
    check("rst_lock",    lock, 0);
    check("rst_timeout", timeout, 0);
    reset_l = 1'b1;

    // Input period 100, gen period 110
    wait_valid(2000, ok);
    check("t1_valid_seen", ok, 1);
    check("t1_delta", delta, EXP_DIFF);
    check("t1_lock", lock, 0);
    check("t1_timeout_low", timeout, 0);
    tick();
    check("t1_valid_pulse", delta_valid, 0);

    // Input noise below hysteresis: gen counter runs out
    noise_in = 1'b1;
    per_gen  = 100;
    seen_to  = 1'b0;
    seen_dv  = 1'b0;
    for (int i = 0; i < 2000 && !seen_to; i++) begin
      tick();
      if (delta_valid) seen_dv = 1'b1;
      if (timeout) seen_to = 1'b1;
    end
    check("t4_timeout_seen", seen_to, 1);
    check("t4_no_valid", seen_dv, 0);
    check("t4_delta_held", delta, EXP_DIFF);
    check("t4_lock", lock, 0);
    tick();
    check("t4_timeout_pulse", timeout, 0);

    // Reset dropped mid-window
    noise_in = 1'b0;
    per_gen  = 110;
    repeat (200) tick();
    reset_l = 1'b0;
    repeat (3) tick();
    check("t5_rst_delta",   delta, 0);
    check("t5_rst_valid",   delta_valid, 0);
    check("t5_rst_lock",    lock, 0);
    check("t5_rst_timeout", timeout, 0);
    reset_l = 1'b1;
    wait_valid(2000, ok);
    check("t5_first_window", ok, 1);
    wait_valid(2000, ok);
    check("t5_full_window", ok, 1);
    check("t5_delta", delta, EXP_DIFF);

    // Matched periods: lock on the 4th in-tolerance window
    reset_l = 1'b0;
    per_gen = 100;
    restart();
    repeat (3) tick();
    reset_l = 1'b1;
    for (int w = 0; w < 4; w++) begin
      wait_valid(1500, ok);
      check($sformatf("t3_valid_w%0d", w), ok, 1);
      check($sformatf("t3_delta_w%0d", w), delta, 0);
      check($sformatf("t3_lock_w%0d", w), lock, (w == 3) ? 1 : 0);
    end

    // clk_en at 1-in-2
    reset_l = 1'b0;
    en_div  = 2;
    per_gen = 110;
    restart();
    repeat (3) tick();
    reset_l = 1'b1;
    wait_valid(4000, ok);
    check("t6_valid_seen", ok, 1);
    check("t6_delta", delta, EXP_DIFF);
    check("t6_lock", lock, 0);
    tick();
    check("t6_valid_pulse", delta_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
